mem_write_monitor: RTL and testbench

//  Reusable, synthesizable checker for data-memory write-bus results in processor testbenches.

---
 rtl/mem_write_monitor_if.sv | 12 +
 rtl/mem_write_monitor.sv | 145 ++++++++++++++
 tb/tb_mem_write_monitor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_monitor_if.sv
// Data-memory write bus observed by mem_write_monitor; the CPU side drives it, the monitor listens.
interface mem_write_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;

  modport master (output MemWrite, DataAdr, WriteData);
  modport slave  (input  MemWrite, DataAdr, WriteData);
endinterface

// File: rtl/mem_write_monitor.sv
// Write-bus checker: pass/fail/timeout verdict, counters and circular write history.
// Optional WRMON_TRACE_EN: simulation trace of accepted writes plus a final summary and $stop.
module mem_write_monitor #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TERM_ADDR   = 252,
  parameter int unsigned EXP_DATA    = 22,
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned TIMEOUT_CYC = 10000,
  parameter int unsigned HIST_DEPTH  = 8,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned PW         = $clog2(HIST_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  mem_write_monitor_if.slave  bus,
  input  logic [PW-1:0]       hist_idx,
  output logic [ADDR_W-1:0]   hist_addr,
  output logic [DATA_W-1:0]   hist_data,
  output logic [PW:0]         hist_count,
  output logic                done,
  output logic                pass,
  output logic [2:0]          fail_code,
  output logic [DATA_W-1:0]   score,
  output logic [CNT_W-1:0]    write_count,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [ADDR_W-1:0] TERM_A  = ADDR_W'(TERM_ADDR);
  localparam logic [ADDR_W:0]   MEM_LIM = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [DATA_W-1:0] EXP_D   = DATA_W'(EXP_DATA);
  localparam logic [31:0]       TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [PW:0]       HC_MAX  = (PW+1)'(HIST_DEPTH);
  localparam logic [PW:0]       HC_ONE  = 1;
  localparam logic [PW-1:0]     PTR_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE = 1;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [ADDR_W-1:0] hist_a [HIST_DEPTH];
  logic [DATA_W-1:0] hist_d [HIST_DEPTH];

  logic          wr_en;
  logic          addr_x;
  logic          misaligned;
  logic          out_of_range;
  logic          timeout_hit;
  logic [PW-1:0] rd_ptr;

  // An unknown strobe counts as a write; an unknown address is reported as misaligned.
  always_comb begin
    wr_en        = (bus.MemWrite !== 1'b0);
    addr_x       = ((^bus.DataAdr) === 1'bx);
    misaligned   = addr_x || (bus.DataAdr[1:0] != 2'b00);
    out_of_range = ({1'b0, bus.DataAdr} >= MEM_LIM);
    timeout_hit  = (TIMEOUT_CYC != 0) && (32'(cycle_count) == TO_LAST);
  end

  always_comb begin
    rd_ptr    = wr_ptr - PTR_ONE - hist_idx;
    hist_addr = '0;
    hist_data = '0;
    if ({1'b0, hist_idx} < hist_count) begin
      hist_addr = hist_a[rd_ptr];
      hist_data = hist_d[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= '0;
      score       <= '0;
      write_count <= '0;
      cycle_count <= '0;
      wr_ptr      <= '0;
      hist_count  <= '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        hist_a[i] <= '0;
        hist_d[i] <= '0;
      end
    end else if (state == S_RUN) begin
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_ONE;
      if (wr_en) begin
        if (write_count != '1) write_count <= write_count + CNT_ONE;
        hist_a[wr_ptr] <= bus.DataAdr;
        hist_d[wr_ptr] <= bus.WriteData;
        wr_ptr         <= wr_ptr + PTR_ONE;
        if (hist_count != HC_MAX) hist_count <= hist_count + HC_ONE;
        if (misaligned) begin
          state     <= S_FAIL;
          done      <= 1'b1;
          fail_code <= 3'd2;
        end else if (out_of_range) begin
          state     <= S_FAIL;
          done      <= 1'b1;
          fail_code <= 3'd3;
        end else if (bus.DataAdr == TERM_A) begin
          done  <= 1'b1;
          score <= bus.WriteData;
          if (bus.WriteData == EXP_D) begin
            state     <= S_PASS;
            pass      <= 1'b1;
            fail_code <= 3'd0;
          end else begin
            state     <= S_FAIL;
            fail_code <= 3'd1;
          end
        end
      end else if (timeout_hit) begin
        state     <= S_TIMEOUT;
        done      <= 1'b1;
        fail_code <= 3'd4;
      end
    end
  end

`ifdef WRMON_TRACE_EN
  logic traced;

  always @(posedge clk) begin
    if (reset && state == S_RUN && wr_en)
      $display("wrmon: cycle=%0d addr=%h data=%h", cycle_count, bus.DataAdr, bus.WriteData);
  end

  // Summary is printed on the first edge that observes a terminal state.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      traced <= 1'b0;
    end else if (!traced && done) begin
      traced <= 1'b1;
      $display("wrmon: done state=%s pass=%0b code=%0d score=%0d writes=%0d cycles=%0d",
               state.name(), pass, fail_code, score, write_count, cycle_count);
      $stop;
    end
  end
`else
  // Trace disabled: purely synthesizable monitor.
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: vector table plus multi-cycle sequences.
module tb_mem_write_monitor;

  logic        clk;
  logic        reset;
  logic [2:0]  hist_idx;
  logic [31:0] hist_addr;
  logic [31:0] hist_data;
  logic [3:0]  hist_count;
  logic        done;
  logic        pass;
  logic [2:0]  fail_code;
  logic [31:0] score;
  logic [15:0] write_count;
  logic [15:0] cycle_count;

  int errors = 0;
  int checks = 0;

  mem_write_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_write_monitor #(
    .ADDR_W(32), .DATA_W(32), .TERM_ADDR(252), .EXP_DATA(22), .MEM_BYTES(256),
    .TIMEOUT_CYC(50), .HIST_DEPTH(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .hist_idx(hist_idx),
    .hist_addr(hist_addr), .hist_data(hist_data), .hist_count(hist_count),
    .done(done), .pass(pass), .fail_code(fail_code), .score(score),
    .write_count(write_count), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        e_done;
    logic        e_pass;
    logic [2:0]  e_code;
    logic [31:0] e_score;
    logic [15:0] e_wc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic we, logic [31:0] a, logic [31:0] d,
                              logic dn, logic ps, logic [2:0] c, logic [31:0] sc,
                              logic [15:0] wc);
    vec_t v;
    v.rst = rst; v.we = we; v.adr = a; v.wd = d;
    v.e_done = dn; v.e_pass = ps; v.e_code = c; v.e_score = sc; v.e_wc = wc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, take the rising edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = we;
    bus.DataAdr   = a;
    bus.WriteData = d;
    reset         = ~rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  vec_t vecs [16];

  initial begin
    hist_idx = '0;
    bus.MemWrite = 1'b0;
    bus.DataAdr = '0;
    bus.WriteData = '0;
    reset = 1'b0;

    vecs[0]  = mk(1, 0, 32'h0,        0,  0, 0, 0, 0,  0);
    vecs[1]  = mk(0, 1, 32'h10,       5,  0, 0, 0, 0,  1);
    vecs[2]  = mk(0, 1, 32'h20,       7,  0, 0, 0, 0,  2);
    vecs[3]  = mk(0, 1, 32'd252,      22, 1, 1, 0, 22, 3);
    vecs[4]  = mk(0, 1, 32'h40,       1,  1, 1, 0, 22, 3);
    vecs[5]  = mk(1, 0, 32'h0,        0,  0, 0, 0, 0,  0);
    vecs[6]  = mk(0, 1, 32'd252,      21, 1, 0, 1, 21, 1);
    vecs[7]  = mk(1, 0, 32'h0,        0,  0, 0, 0, 0,  0);
    vecs[8]  = mk(0, 1, 32'h22,       9,  1, 0, 2, 0,  1);
    vecs[9]  = mk(1, 0, 32'h0,        0,  0, 0, 0, 0,  0);
    vecs[10] = mk(0, 1, 32'h100,      9,  1, 0, 3, 0,  1);
    vecs[11] = mk(1, 0, 32'h0,        0,  0, 0, 0, 0,  0);
    vecs[12] = mk(0, 1, 32'h101,      9,  1, 0, 2, 0,  1);
    vecs[13] = mk(1, 0, 32'h0,        0,  0, 0, 0, 0,  0);
    vecs[14] = mk(0, 1, 32'h0,        3,  0, 0, 0, 0,  1);
    vecs[15] = mk(0, 1, 32'hFFFFFFFC, 3,  1, 0, 3, 0,  2);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].we, vecs[i].adr, vecs[i].wd);
      chk($sformatf("v%0d_done", i),  done,        vecs[i].e_done);
      chk($sformatf("v%0d_pass", i),  pass,        vecs[i].e_pass);
      chk($sformatf("v%0d_code", i),  fail_code,   vecs[i].e_code);
      chk($sformatf("v%0d_score", i), score,       vecs[i].e_score);
      chk($sformatf("v%0d_wc", i),    write_count, vecs[i].e_wc);
    end

    // Pass at cycle 40, then everything stays frozen.
    step(1'b1, 1'b0, 0, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_hcount", hist_count, 0);
    chk("rst_haddr", hist_addr, 0);
    idle(37);
    step(1'b0, 1'b1, 32'h10, 5);
    step(1'b0, 1'b1, 32'h20, 7);
    chk("t1_pre_cycle", cycle_count, 39);
    chk("t1_pre_done", done, 0);
    step(1'b0, 1'b1, 32'd252, 22);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_code", fail_code, 0);
    chk("t1_score", score, 22);
    chk("t1_wc", write_count, 3);
    chk("t1_cycle", cycle_count, 40);
    idle(5);
    step(1'b0, 1'b1, 32'h30, 1);
    chk("t1_frozen_cycle", cycle_count, 40);
    chk("t1_frozen_wc", write_count, 3);
    chk("t1_hcount", hist_count, 3);
    hist_idx = 3'd0; #1;
    chk("t1_h0_addr", hist_addr, 252);
    chk("t1_h0_data", hist_data, 22);
    hist_idx = 3'd2; #1;
    chk("t1_h2_addr", hist_addr, 32'h10);
    chk("t1_h2_data", hist_data, 5);
    hist_idx = 3'd3; #1;
    chk("t1_h3_addr", hist_addr, 0);
    chk("t1_h3_data", hist_data, 0);
    hist_idx = 3'd0;

    // Timeout after 50 idle cycles.
    step(1'b1, 1'b0, 0, 0);
    idle(49);
    chk("to_pre_done", done, 0);
    chk("to_pre_cycle", cycle_count, 49);
    idle(1);
    chk("to_done", done, 1);
    chk("to_pass", pass, 0);
    chk("to_code", fail_code, 4);
    chk("to_cycle", cycle_count, 50);
    step(1'b0, 1'b1, 32'd252, 22);
    chk("to_sticky_code", fail_code, 4);
    chk("to_sticky_wc", write_count, 0);

    // Write on the timeout edge wins.
    step(1'b1, 1'b0, 0, 0);
    idle(49);
    step(1'b0, 1'b1, 32'd252, 22);
    chk("tow_pass", pass, 1);
    chk("tow_code", fail_code, 0);
    chk("tow_cycle", cycle_count, 50);

    // History wrap: 11 writes into 8 entries.
    step(1'b1, 1'b0, 0, 0);
    for (int i = 1; i <= 11; i++) step(1'b0, 1'b1, 32'(4 * i), 32'(100 + i));
    chk("h_count", hist_count, 8);
    chk("h_wc", write_count, 11);
    chk("h_done", done, 0);
    hist_idx = 3'd0; #1;
    chk("h_idx0_addr", hist_addr, 44);
    chk("h_idx0_data", hist_data, 111);
    hist_idx = 3'd7; #1;
    chk("h_idx7_addr", hist_addr, 16);
    chk("h_idx7_data", hist_data, 104);
    hist_idx = 3'd0;

    // Reset mid-run discards state and an in-flight write.
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 32'h4, 1);
    step(1'b0, 1'b1, 32'h8, 2);
    step(1'b0, 1'b1, 32'hC, 3);
    chk("mr_wc_pre", write_count, 3);
    bus.MemWrite = 1'b1; bus.DataAdr = 32'd252; bus.WriteData = 22;
    reset = 1'b0; #1;
    chk("mr_async_wc", write_count, 0);
    chk("mr_async_cycle", cycle_count, 0);
    chk("mr_async_hcount", hist_count, 0);
    chk("mr_async_haddr", hist_addr, 0);
    @(posedge clk); #1;
    chk("mr_inflight_wc", write_count, 0);
    chk("mr_inflight_done", done, 0);
    chk("mr_inflight_pass", pass, 0);
    step(1'b0, 1'b1, 32'd252, 22);
    chk("mr_wc", write_count, 1);
    chk("mr_pass", pass, 1);
    chk("mr_cycle", cycle_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
